matrix_mul_seq: RTL and testbench
=================================

MATRIX_MUL_SEQ -- requirements
Module: matrix_mul_seq

Interface
REQ-001 SHALL use one clock and a synchronous, active-low reset: one clock; reset is synchronous and active-low.
REQ-002 SHALL have parameter KLEN_W, default 4, the width of the k_len step-count input.
REQ-003 SHALL have port clk  in  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port rstn  in  1  synchronous active-low reset.
REQ-005 SHALL have port start  in  1  job request; sampled only in IDLE.
REQ-006 SHALL have port k_len  in  KLEN_W  number of rank-1 update steps; sampled with start.
REQ-007 SHALL have port acc_clr  in  1  clear the accumulator at job start; sampled with start.
REQ-008 SHALL have port abort  in  1  cancel the current job.
REQ-009 SHALL have ports opnd_valid (in, 1), opnd_ready (out, 1), opnd_a (in, 32) and opnd_b (in, 32), carrying one column of A and one row of B, four int8 lanes each.
REQ-010 SHALL have datapath ports mul_ctrl_o (out, 4), op_a_o (out, 32), op_b_o (out, 32), acc_o[3:0] (out, 32 each) and mul_res_i[3:0] (in, 32 each).
REQ-011 SHALL have result ports busy (out, 1), done (out, 1, single-cycle pulse) and res[3:0] (out, 32 each), with res equal to the accumulator rows.

Function
REQ-012 SHALL implement the states IDLE, RUN and DONE.
REQ-013 SHALL go from IDLE to RUN on start=1 with k_len!=0, latching k_len into klen_q and clearing the step counter.
REQ-014 SHALL go from IDLE straight to DONE on start=1 with k_len=0, leaving the accumulator untouched apart from acc_clr handling.
REQ-015 SHALL drive opnd_ready=1 only in RUN.
REQ-016 SHALL treat opnd_valid&&opnd_ready as one step.
REQ-017 SHALL drive mul_ctrl_o with the `MATRIX_MUL encoding from define.vh only while in RUN with opnd_valid=1, and 4'b0 otherwise.
REQ-018 SHALL pass opnd_a and opnd_b straight through to op_a_o and op_b_o, and drive acc_o from the accumulator rows at all times.
REQ-019 SHALL, on each step, load acc[i] from mul_res_i[i] for i=0..3 and increment the step counter by 1.
REQ-020 SHALL complete a step with zero added latency: the result is written on the same edge that completes the handshake.
REQ-021 SHALL go from RUN to DONE on the edge of the step that makes the counter equal klen_q.
REQ-022 SHALL assert done=1 for exactly one cycle while in DONE, then return to IDLE.
REQ-023 SHALL drive busy=1 in RUN and DONE.
REQ-024 SHALL give each byte lane wrap-around modulo 256 arithmetic (the datapath result); no saturation and no flags.
REQ-025 SHALL ignore start while busy=1, leaving k_len and acc_clr unlatched.
REQ-026 SHALL hold the accumulator and counter on cycles in RUN with opnd_valid=0; no timeout.
REQ-027 SHALL, on abort=1 in RUN, go to IDLE on the next edge, accept no step on that edge, retain the accumulator and produce no done pulse; abort SHALL have priority over a simultaneous handshake.
REQ-028 SHALL ignore abort in IDLE and DONE.
REQ-029 SHALL allow a new start in the cycle after DONE, so back-to-back jobs are separated by exactly one idle cycle.

Reset
REQ-030 SHALL, while rstn=0 at a clock edge, set state=IDLE, counter=0, klen_q=0 and acc[3:0]=0.
REQ-031 SHALL, during and after reset, hold busy=0, done=0, opnd_ready=0, mul_ctrl_o=0 and res=0.
REQ-032 SHALL give reset priority over start, abort and the handshake; a reset during RUN discards the job without a done pulse.

Configuration
REQ-033 SHALL, when MATRIX_MUL_ACC_EN is defined, zero the accumulator at job start only if acc_clr=1, and otherwise keep the previous result so that jobs chain.
REQ-034 SHALL, when MATRIX_MUL_ACC_EN is undefined, ignore acc_clr and always zero the accumulator at every accepted start (including k_len=0); the port SHALL remain present.

Verification
REQ-035 SHALL cover: k_len=1, acc_clr=1, opnd_a=32'h01010101, opnd_b=32'h02020202 -> done 2 cycles after start, with all four res rows = 32'h02020202.
REQ-036 SHALL cover: k_len=1, opnd_a=32'h000000FF, opnd_b=32'h00000002 from a zero accumulator -> res[0]=32'h000000FE and res[3:1]=0 (wrap-around).
REQ-037 SHALL cover: k_len=4, with opnd_valid low in 2 cycles between steps -> done exactly 7 cycles after start, and mul_ctrl_o=0 in the gap cycles.
REQ-038 SHALL cover: abort after 2 of 4 steps -> IDLE on the next cycle, no done, res equal to the 2-step partial sum, and a following start accepted.
REQ-039 SHALL cover: with MATRIX_MUL_ACC_EN, two k_len=1 jobs with 01/01 operands, the second with acc_clr=0 -> res rows = 32'h02020202; without the macro -> 32'h01010101.
REQ-040 SHALL cover: rstn=0 pulsed mid-RUN -> all outputs zero on the next cycle, and start ignored during reset.

Source files
------------

// File: rtl/matrix_mul_seq.sv
// matrix_mul_seq: sequences a 4x4 int8 outer-product accumulation over k_len steps.
// Each accepted operand pair (column of A, row of B) is handed to an external
// multiply-accumulate datapath; its result is written back into the accumulator rows.
// Build option: define MATRIX_MUL_ACC_EN to let acc_clr=0 keep the previous result
// across jobs; without it every accepted start zeroes the accumulator.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting operand steps until klen_q steps are done
// DONE  | one-cycle done pulse, then back to IDLE

`ifndef MATRIX_MUL
`define MATRIX_MUL 4'b1010
`endif

module matrix_mul_seq #(
    parameter int KLEN_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [KLEN_W-1:0] k_len,
    input  logic              acc_clr,
    input  logic              abort,
    input  logic              opnd_valid,
    output logic              opnd_ready,
    input  logic [31:0]       opnd_a,
    input  logic [31:0]       opnd_b,
    output logic [3:0]        mul_ctrl_o,
    output logic [31:0]       op_a_o,
    output logic [31:0]       op_b_o,
    output logic [31:0]       acc_o [4],
    input  logic [31:0]       mul_res_i [4],
    output logic              busy,
    output logic              done,
    output logic [31:0]       res [4]
);

    localparam logic [3:0] MUL_CTRL_MATRIX = `MATRIX_MUL;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [KLEN_W-1:0] klen_q;
    logic [KLEN_W-1:0] cnt;
    logic [KLEN_W-1:0] cnt_nxt;
    logic [31:0]       acc [4];
    logic              clr_on_start;

`ifdef MATRIX_MUL_ACC_EN
    assign clr_on_start = acc_clr;
`else
    // The port stays for interface compatibility; every job starts from zero.
    logic unused_acc_clr;
    assign unused_acc_clr = acc_clr;
    assign clr_on_start   = 1'b1;
`endif

    assign cnt_nxt = cnt + 1'b1;

    // Operand request goes out to the datapath only while a step can complete.
    assign mul_ctrl_o = ((state == RUN) && opnd_valid) ? MUL_CTRL_MATRIX : 4'b0;
    assign op_a_o     = opnd_a;
    assign op_b_o     = opnd_b;

    // Accumulator rows are visible both to the datapath and as the result.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            acc_o[i] = acc[i];
            res[i]   = acc[i];
        end
    end

    // Sequencer: state, step counter, accumulator and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            klen_q     <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            opnd_ready <= 1'b0;
            for (int i = 0; i < 4; i++) acc[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        klen_q <= k_len;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        if (clr_on_start) begin
                            for (int i = 0; i < 4; i++) acc[i] <= '0;
                        end
                        if (k_len != '0) begin
                            state      <= RUN;
                            opnd_ready <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // abort wins over a handshake on the same edge
                    if (abort) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        opnd_ready <= 1'b0;
                    end else if (opnd_valid) begin
                        for (int i = 0; i < 4; i++) acc[i] <= mul_res_i[i];
                        cnt <= cnt_nxt;
                        if (cnt_nxt == klen_q) begin
                            state      <= DONE;
                            opnd_ready <= 1'b0;
                            done       <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    opnd_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mul_seq.sv
// Testbench for matrix_mul_seq: random jobs against a matrix-level reference model,
// with a scoreboard monitor checking res on every done pulse.

`ifndef MATRIX_MUL
`define MATRIX_MUL 4'b1010
`endif

module tb_matrix_mul_seq;

    localparam int KLEN_W = 4;
    localparam logic [3:0] MM = `MATRIX_MUL;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic [KLEN_W-1:0] k_len;
    logic              acc_clr;
    logic              abort;
    logic              opnd_valid;
    logic              opnd_ready;
    logic [31:0]       opnd_a;
    logic [31:0]       opnd_b;
    logic [3:0]        mul_ctrl_o;
    logic [31:0]       op_a_o;
    logic [31:0]       op_b_o;
    logic [31:0]       acc_o [4];
    logic [31:0]       mul_res_i [4];
    logic              busy;
    logic              done;
    logic [31:0]       res [4];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    bit [31:0] exp_q [$];
    int        m [4][4];
    bit [31:0] job_a [16];
    bit [31:0] job_b [16];
    int        job_gap [16];

    matrix_mul_seq #(.KLEN_W(KLEN_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .k_len      (k_len),
        .acc_clr    (acc_clr),
        .abort      (abort),
        .opnd_valid (opnd_valid),
        .opnd_ready (opnd_ready),
        .opnd_a     (opnd_a),
        .opnd_b     (opnd_b),
        .mul_ctrl_o (mul_ctrl_o),
        .op_a_o     (op_a_o),
        .op_b_o     (op_b_o),
        .acc_o      (acc_o),
        .mul_res_i  (mul_res_i),
        .busy       (busy),
        .done       (done),
        .res        (res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External datapath: per-lane acc + a_i*b_j mod 256, only when requested.
    function automatic logic [31:0] lane_mac(input logic [31:0] acc_row, input logic [7:0] a_lane,
                                             input logic [31:0] b_row);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = acc_row[8*j +: 8] + a_lane * b_row[8*j +: 8];
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mul_res_i[i] = (mul_ctrl_o == MM) ? lane_mac(acc_o[i], op_a_o[8*i +: 8], op_b_o)
                                              : 32'hDEAD_BEEF;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: C[i][j] accumulates A column lane i times B row lane j, mod 256.
    task automatic model_zero();
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m[i][j] = 0;
    endtask

    task automatic model_start(input bit clr);
`ifdef MATRIX_MUL_ACC_EN
        if (clr) model_zero();
`else
        model_zero();
`endif
    endtask

    task automatic model_step(input bit [31:0] a, input bit [31:0] b);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                m[i][j] = (m[i][j] + int'(a[8*i +: 8]) * int'(b[8*j +: 8])) % 256;
    endtask

    function automatic bit [31:0] mrow(input int i);
        bit [31:0] r;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = 8'(m[i][j]);
        return r;
    endfunction

    // Scoreboard monitor: every done pulse must match the next expected result.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() < 4) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected_done actual=done required=no_done (t=%0t)", $time);
            end else begin
                for (int i = 0; i < 4; i++) chk($sformatf("sb_res%0d", i), res[i], exp_q.pop_front());
            end
            if (done_prev === 1'b1) chk("done_single_cycle", 32'(done_prev), 32'(1'b0));
        end
        done_prev <= done;
    end

    task automatic fill_rand(input int gap_max);
        for (int s = 0; s < 16; s++) begin
            job_a[s]   = $urandom;
            job_b[s]   = $urandom;
            job_gap[s] = (s == 0) ? 0 : int'($urandom_range(0, gap_max));
        end
    endtask

    // Issue one job; abort_after < 0 means run to completion.
    task automatic run_job(input int klen, input bit clr, input int abort_after);
        int t0;
        int gaps;
        int nsteps;
        gaps   = 0;
        nsteps = (abort_after < 0) ? klen : abort_after;
        model_start(clr);
        for (int s = 0; s < nsteps; s++) model_step(job_a[s], job_b[s]);
        if (abort_after < 0) for (int i = 0; i < 4; i++) exp_q.push_back(mrow(i));

        start   = 1'b1;
        k_len   = klen[KLEN_W-1:0];
        acc_clr = clr;
        abort   = 1'($urandom_range(0, 1));
        t0      = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        if (klen == 0) begin
            chk("k0_done", 32'(done), 32'd1);
            chk("k0_latency", 32'(cyc - t0), 32'd1);
        end else begin
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_ready", 32'(opnd_ready), 32'd1);
            for (int s = 0; s < klen; s++) begin
                if (s == abort_after) begin
                    abort      = 1'b1;
                    opnd_valid = 1'b1;
                    opnd_a     = $urandom;
                    opnd_b     = $urandom;
                    @(posedge clk); #1;
                    abort      = 1'b0;
                    opnd_valid = 1'b0;
                    chk("abort_busy", 32'(busy), 32'd0);
                    chk("abort_ready", 32'(opnd_ready), 32'd0);
                    chk("abort_done", 32'(done), 32'd0);
                    for (int i = 0; i < 4; i++) chk($sformatf("abort_res%0d", i), res[i], mrow(i));
                    return;
                end
                for (int g = 0; g < job_gap[s]; g++) begin
                    opnd_valid = 1'b0;
                    opnd_a     = $urandom;
                    opnd_b     = $urandom;
                    #1;
                    chk("gap_ctrl", 32'(mul_ctrl_o), 32'd0);
                    @(posedge clk); #1;
                    gaps++;
                end
                opnd_valid = 1'b1;
                opnd_a     = job_a[s];
                opnd_b     = job_b[s];
                start      = 1'($urandom_range(0, 1));
                k_len      = KLEN_W'($urandom);
                acc_clr    = 1'($urandom_range(0, 1));
                #1;
                chk("step_ctrl", 32'(mul_ctrl_o), 32'(MM));
                @(posedge clk); #1;
            end
            opnd_valid = 1'b0;
            start      = 1'b0;
            chk("done_pulse", 32'(done), 32'd1);
            chk("done_latency", 32'(cyc - t0), 32'(1 + klen + gaps));
        end
        @(posedge clk); #1;
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_ready"}, 32'(opnd_ready), 32'd0);
        chk({tag, "_ctrl"}, 32'(mul_ctrl_o), 32'd0);
        for (int i = 0; i < 4; i++) chk($sformatf("%s_res%0d", tag, i), res[i], 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn       = 1'b0;
        start      = 1'b1;
        k_len      = 4'd3;
        acc_clr    = 1'b1;
        abort      = 1'b0;
        opnd_valid = 1'b1;
        opnd_a     = 32'h0101_0101;
        opnd_b     = 32'h0101_0101;
        model_zero();
        repeat (3) @(posedge clk);
        #1;
        opnd_valid = 1'b0;
        #1;
        chk_all_zero("reset");
        rstn  = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_busy", 32'(busy), 32'd0);

        // 1x1 ones by twos
        job_a[0] = 32'h0101_0101; job_b[0] = 32'h0202_0202; job_gap[0] = 0;
        run_job(1, 1'b1, -1);
        for (int i = 0; i < 4; i++) chk($sformatf("ones_twos_res%0d", i), res[i], 32'h0202_0202);

        // lane wrap-around
        job_a[0] = 32'h0000_00FF; job_b[0] = 32'h0000_0002;
        run_job(1, 1'b1, -1);
        chk("wrap_res0", res[0], 32'h0000_00FE);
        for (int i = 1; i < 4; i++) chk($sformatf("wrap_res%0d", i), res[i], 32'h0);

        // four steps with two gap cycles: done 7 cycles after start
        fill_rand(0);
        job_gap[1] = 1; job_gap[3] = 1;
        run_job(4, 1'b1, -1);

        // abort after two of four steps, then a new job is accepted
        fill_rand(1);
        run_job(4, 1'b1, 2);
        fill_rand(1);
        run_job(2, 1'b0, -1);

        // chaining two jobs
        job_a[0] = 32'h0101_0101; job_b[0] = 32'h0101_0101; job_gap[0] = 0;
        run_job(1, 1'b1, -1);
        run_job(1, 1'b0, -1);
`ifdef MATRIX_MUL_ACC_EN
        for (int i = 0; i < 4; i++) chk($sformatf("chain_res%0d", i), res[i], 32'h0202_0202);
`else
        for (int i = 0; i < 4; i++) chk($sformatf("chain_res%0d", i), res[i], 32'h0101_0101);
`endif

        // zero-length jobs, with and without clear
        run_job(0, 1'b0, -1);
        run_job(0, 1'b1, -1);

        // longest job
        fill_rand(1);
        run_job(15, 1'b1, -1);

        // random jobs
        for (int n = 0; n < 30; n++) begin
            int kl;
            int ab;
            kl = int'($urandom_range(0, 15));
            ab = (kl > 1 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, kl - 1)) : -1;
            fill_rand(2);
            run_job(kl, 1'($urandom_range(0, 1)), ab);
        end

        // reset in the middle of a job
        fill_rand(0);
        start   = 1'b1;
        k_len   = 4'd3;
        acc_clr = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        opnd_valid = 1'b1;
        opnd_a     = job_a[0];
        opnd_b     = job_b[0];
        @(posedge clk); #1;
        rstn  = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        opnd_valid = 1'b0;
        #1;
        chk_all_zero("midrun_reset");
        @(posedge clk); #1;
        chk("reset_start_ignored", 32'(busy), 32'd0);
        rstn  = 1'b1;
        start = 1'b0;
        model_zero();
        @(posedge clk); #1;
        chk("after_reset_busy", 32'(busy), 32'd0);

        fill_rand(1);
        run_job(3, 1'b0, -1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
